// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared encodings for the RV32I decoder/control unit: major opcodes,
// func3/func7 values, immediate formats, ALU operations, write-back
// sources and next-PC selects. The datapath muxes and the ALU import the
// same package so both sides of every select agree on the encoding.
package ctrl_pkg;

    // Major opcodes (instr[6:2])
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    // func3 values for OP / OP_IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // func7 value selecting SUB / SRA
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_U    = 3'd1,
        IMM_B    = 3'd2,
        IMM_S    = 3'd3,
        IMM_I    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_COPY_B = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        RD_IMM  = 2'b00,
        RD_PC4  = 2'b01,
        RD_ALU  = 2'b10,
        RD_LOAD = 2'b11
    } rd_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4   = 2'b00,
        PC_ALU     = 2'b01,
        PC_ALU_CLR = 2'b10
    } pc_sel_e;

endpackage

// File: rtl/ctrl_alu_dec.sv
// ctrl_alu_dec
// Purely combinational ALU-operation decoder.
// Ports:
//   opcode  in  5  major opcode (instr[6:2])
//   func3   in  3  instr[14:12]
//   func7   in  7  instr[31:25]
//   alu_op  out 4  ALU operation code (ctrl_pkg::alu_op_e encoding)
module ctrl_alu_dec
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [3:0] alu_op
);

    alu_op_e op;
    logic    is_reg;
    logic    alt;

    assign is_reg = (opcode == OPC_OP);
    assign alt    = (func7 == F7_ALT);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        op = ALU_ADD;
        if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
            unique case (func3)
                // Immediate form has no SUB: func7 bits are part of the immediate.
                F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
                F3_SLL:  op = ALU_SLL;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_XOR:  op = ALU_XOR;
                F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
                F3_OR:   op = ALU_OR;
                F3_AND:  op = ALU_AND;
                default: op = ALU_ADD;
            endcase
        end else if (opcode == OPC_LUI) begin
            op = ALU_COPY_B;
        end
    end

    assign alu_op = op;

endmodule

// File: rtl/ctrl.sv
// ctrl
// Main decoder and control unit of the single-issue RV32I core. Datapath
// selects are pure functions of opcode/func3/func7. Side-effecting outputs
// (register write, memory access, next-PC redirect) are gated by reset and
// by a one-cycle flush that squashes the instruction after a taken
// control transfer.
// Ports:
//   clk        in  1  core clock, rising edge
//   rst        in  1  synchronous active-high reset
//   opcode     in  5  instr[6:2]
//   func3      in  3  instr[14:12]
//   func7      in  7  instr[31:25]
//   b          in  1  branch comparator result
//   imm_type   out 3  immediate format
//   alu1_sel   out 1  ALU A: 0 rs1, 1 PC
//   alu2_sel   out 1  ALU B: 0 rs2, 1 immediate
//   alu_op     out 4  ALU operation
//   rd_sel     out 2  write-back source
//   rf_we      out 1  register-file write enable
//   mem_we     out 1  data-memory write
//   mem_re     out 1  data-memory read
//   mem_func3  out 3  func3 pass-through for load/store sizing
//   pc_sel     out 2  next-PC select
module ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       b,
    output logic [2:0] imm_type,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [3:0] alu_op,
    output logic [1:0] rd_sel,
    output logic       rf_we,
    output logic       mem_we,
    output logic       mem_re,
    output logic [2:0] mem_func3,
    output logic [1:0] pc_sel
);

    imm_type_e imm_d;
    rd_sel_e   rd_d;
    pc_sel_e   pc_d;
    logic      a1_d;
    logic      a2_d;
    logic      rf_we_d;
    logic      mem_we_d;
    logic      mem_re_d;
    logic      flush;
    logic      squash;

    ctrl_alu_dec u_alu_dec (
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .alu_op (alu_op)
    );

    // Raw decode: independent of rst and flush.
    always_comb begin
        imm_d    = IMM_NONE;
        rd_d     = RD_ALU;
        pc_d     = PC_PLUS4;
        a1_d     = 1'b0;
        a2_d     = 1'b1;
        rf_we_d  = 1'b0;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
        case (opcode)
            OPC_OP: begin
                a2_d    = 1'b0;
                rf_we_d = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_d   = IMM_I;
                rf_we_d = 1'b1;
            end
            OPC_LOAD: begin
                imm_d    = IMM_I;
                rd_d     = RD_LOAD;
                rf_we_d  = 1'b1;
                mem_re_d = 1'b1;
            end
            OPC_STORE: begin
                imm_d    = IMM_S;
                mem_we_d = 1'b1;
            end
            OPC_LUI: begin
                imm_d   = IMM_U;
                rd_d    = RD_IMM;
                rf_we_d = 1'b1;
            end
            OPC_AUIPC: begin
                imm_d   = IMM_U;
                a1_d    = 1'b1;
                rf_we_d = 1'b1;
            end
            OPC_JAL: begin
                imm_d   = IMM_J;
                a1_d    = 1'b1;
                rd_d    = RD_PC4;
                rf_we_d = 1'b1;
                pc_d    = PC_ALU;
            end
            OPC_JALR: begin
                imm_d   = IMM_I;
                rd_d    = RD_PC4;
                rf_we_d = 1'b1;
                pc_d    = PC_ALU_CLR;
            end
            OPC_BRANCH: begin
                imm_d = IMM_B;
                a1_d  = 1'b1;
                pc_d  = b ? PC_ALU : PC_PLUS4;
            end
            default: ;
        endcase
    end

    assign imm_type  = imm_d;
    assign alu1_sel  = a1_d;
    assign alu2_sel  = a2_d;
    assign rd_sel    = rd_d;
    assign mem_func3 = func3;

    // Reset and a pending flush both kill the instruction's side effects.
    assign squash = rst | flush;
    assign rf_we  = rf_we_d  & ~squash;
    assign mem_we = mem_we_d & ~squash;
    assign mem_re = mem_re_d & ~squash;
    assign pc_sel = squash ? 2'(PC_PLUS4) : 2'(pc_d);

    // pc_sel is already gated, so a squashed transfer never re-arms flush.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) flush <= 1'b0;
        else     flush <= (pc_sel != 2'(PC_PLUS4));
    end

endmodule

// File: tb/tb_ctrl.sv
// tb_ctrl
// Self-checking bench for ctrl: directed scenarios followed by randomized
// instruction streams, all compared against a behavioural model.
module tb_ctrl;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] opcode = 5'd0;
    logic [2:0] func3 = 3'd0;
    logic [6:0] func7 = 7'd0;
    logic       b = 1'b0;
    logic [2:0] imm_type;
    logic       alu1_sel, alu2_sel, rf_we, mem_we, mem_re;
    logic [3:0] alu_op;
    logic [1:0] rd_sel, pc_sel;
    logic [2:0] mem_func3;

    int n_cmp = 0;
    int n_bad = 0;
    bit m_flush = 1'b0;   // model of the squash state

    always #5 clk = ~clk;

    ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
        .imm_type(imm_type), .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .alu_op(alu_op),
        .rd_sel(rd_sel), .rf_we(rf_we), .mem_we(mem_we), .mem_re(mem_re),
        .mem_func3(mem_func3), .pc_sel(pc_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t op=%b f3=%b f7=%b b=%b rst=%b)",
                     tag, got, exp, $time, opcode, func3, func7, b, rst);
        end
    endtask

    // Reference model: spec rules written as set membership and tables.
    function automatic logic [3:0] m_alu(input logic [4:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
        logic [3:0] tab [8];
        logic [3:0] r;
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (op == OPC_LUI) return 4'd10;
        if (!(op inside {OPC_OP, OPC_OP_IMM})) return 4'd0;
        r = tab[f3];
        // SUB follows ADD and SRA follows SRL in the encoding.
        if (f7 == 7'b0100000 && (f3 == 3'd5 || (f3 == 3'd0 && op == OPC_OP))) r = r + 4'd1;
        return r;
    endfunction

    function automatic logic [2:0] m_imm(input logic [4:0] op);
        if (op inside {OPC_LUI, OPC_AUIPC})            return 3'd1;
        if (op inside {OPC_OP_IMM, OPC_LOAD, OPC_JALR}) return 3'd4;
        if (op == OPC_STORE)  return 3'd3;
        if (op == OPC_BRANCH) return 3'd2;
        if (op == OPC_JAL)    return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic [1:0] m_rd(input logic [4:0] op);
        if (op == OPC_LUI) return 2'b00;
        if (op inside {OPC_JAL, OPC_JALR}) return 2'b01;
        if (op == OPC_LOAD) return 2'b11;
        return 2'b10;
    endfunction

    function automatic logic [1:0] m_pc(input logic [4:0] op, input logic bb);
        if (op == OPC_JAL || (op == OPC_BRANCH && bb)) return 2'b01;
        if (op == OPC_JALR) return 2'b10;
        return 2'b00;
    endfunction

    // One instruction per cycle: drive after the edge, check mid-cycle,
    // then advance the model's flush state for the next edge.
    task automatic step(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic bb, input logic r);
        logic       kill;
        logic [1:0] pc_raw;
        @(posedge clk);
        #1;
        opcode = op; func3 = f3; func7 = f7; b = bb; rst = r;
        #4;
        kill   = r || m_flush;
        pc_raw = m_pc(op, bb);
        check("imm_type", 32'(imm_type), 32'(m_imm(op)));
        check("alu1_sel", 32'(alu1_sel), 32'(op inside {OPC_JAL, OPC_BRANCH, OPC_AUIPC}));
        check("alu2_sel", 32'(alu2_sel), 32'(op != OPC_OP));
        check("alu_op",   32'(alu_op),   32'(m_alu(op, f3, f7)));
        check("rd_sel",   32'(rd_sel),   32'(m_rd(op)));
        check("mem_func3", 32'(mem_func3), 32'(f3));
        check("rf_we", 32'(rf_we), 32'(!kill && (op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD,
                                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR})));
        check("mem_we", 32'(mem_we), 32'(!kill && op == OPC_STORE));
        check("mem_re", 32'(mem_re), 32'(!kill && op == OPC_LOAD));
        check("pc_sel", 32'(pc_sel), kill ? 32'd0 : 32'(pc_raw));
        m_flush = !kill && (pc_raw != 2'b00);
    endtask

    logic [4:0] valid_ops [9];

    initial begin
        valid_ops = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI,
                      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH};

        // Reset: even a JAL is fully gated.
        step(OPC_JAL, 3'd0, 7'd0, 1'b0, 1'b1);
        step(OPC_JAL, 3'd0, 7'd0, 1'b0, 1'b1);
        check("rst_pc_sel", 32'(pc_sel), 32'd0);
        check("rst_rf_we",  32'(rf_we),  32'd0);

        // LUI, OP_IMM, STORE
        step(OPC_LUI, 3'd0, 7'd0, 1'b0, 1'b0);
        check("lui_imm", 32'(imm_type), 32'd1);
        check("lui_rd",  32'(rd_sel),   32'd0);
        check("lui_alu", 32'(alu_op),   32'd10);
        step(OPC_OP_IMM, 3'd0, 7'd0, 1'b0, 1'b0);
        check("opimm_imm", 32'(imm_type), 32'd4);
        step(OPC_STORE, 3'd2, 7'd0, 1'b0, 1'b0);
        check("store_imm", 32'(imm_type), 32'd3);
        check("store_we",  32'(mem_we),   32'd1);

        // JAL then LOAD (LOAD is squashed by the JAL)
        step(OPC_JAL, 3'd0, 7'd0, 1'b0, 1'b0);
        check("jal_a1", 32'(alu1_sel), 32'd1);
        check("jal_rd", 32'(rd_sel),   32'd1);
        check("jal_pc", 32'(pc_sel),   32'd1);
        check("jal_imm", 32'(imm_type), 32'd5);
        step(OPC_LOAD, 3'd4, 7'd0, 1'b0, 1'b0);
        check("load_sq_re", 32'(mem_re), 32'd0);
        step(OPC_LOAD, 3'd4, 7'd0, 1'b0, 1'b0);
        check("load_a1", 32'(alu1_sel), 32'd0);
        check("load_rd", 32'(rd_sel),   32'd3);
        check("load_re", 32'(mem_re),   32'd1);

        // alu2_sel pattern and unknown opcode
        step(OPC_OP, 3'd0, 7'd0, 1'b0, 1'b0);
        check("a2_op", 32'(alu2_sel), 32'd0);
        step(5'b10101, 3'd0, 7'd0, 1'b0, 1'b0);
        check("a2_unk", 32'(alu2_sel), 32'd1);
        check("unk_rf_we", 32'(rf_we), 32'd0);
        step(OPC_OP_IMM, 3'd0, 7'd0, 1'b0, 1'b0);
        check("a2_opimm", 32'(alu2_sel), 32'd1);
        step(OPC_OP, 3'd0, 7'd0, 1'b0, 1'b0);
        check("a2_op2", 32'(alu2_sel), 32'd0);

        // func7 alternates
        step(OPC_OP, 3'd0, 7'b0100000, 1'b0, 1'b0);
        check("sub", 32'(alu_op), 32'd1);
        step(OPC_OP_IMM, 3'd5, 7'b0100000, 1'b0, 1'b0);
        check("srai", 32'(alu_op), 32'd7);
        step(OPC_OP_IMM, 3'd0, 7'b0100000, 1'b0, 1'b0);
        check("addi_alt", 32'(alu_op), 32'd0);

        // Branches and squash timing
        step(OPC_BRANCH, 3'd0, 7'd0, 1'b0, 1'b0);
        check("br_nt", 32'(pc_sel), 32'd0);
        step(OPC_BRANCH, 3'd0, 7'd0, 1'b1, 1'b0);
        check("br_t", 32'(pc_sel), 32'd1);
        step(OPC_OP, 3'd0, 7'd0, 1'b0, 1'b0);
        check("br_sq", 32'(rf_we), 32'd0);
        step(OPC_OP, 3'd0, 7'd0, 1'b0, 1'b0);
        check("br_after", 32'(rf_we), 32'd1);

        // Back-to-back transfers: second squashed, third runs
        step(OPC_JAL, 3'd0, 7'd0, 1'b0, 1'b0);
        step(OPC_JAL, 3'd0, 7'd0, 1'b0, 1'b0);
        check("b2b_sq_pc", 32'(pc_sel), 32'd0);
        step(OPC_OP, 3'd0, 7'd0, 1'b0, 1'b0);
        check("b2b_after", 32'(rf_we), 32'd1);

        // JALR under reset, then without
        step(OPC_JALR, 3'd0, 7'd0, 1'b0, 1'b1);
        check("jalr_rst_pc", 32'(pc_sel), 32'd0);
        check("jalr_rst_we", 32'(rf_we),  32'd0);
        step(OPC_OP, 3'd0, 7'd0, 1'b0, 1'b0);
        check("jalr_rst_noflush", 32'(rf_we), 32'd1);
        step(OPC_JALR, 3'd0, 7'd0, 1'b0, 1'b0);
        check("jalr_pc", 32'(pc_sel), 32'd2);
        check("jalr_we", 32'(rf_we),  32'd1);

        // Reset asserted while flush is pending clears it on the same edge.
        step(OPC_OP, 3'd0, 7'd0, 1'b0, 1'b1);
        step(OPC_OP, 3'd0, 7'd0, 1'b0, 1'b0);
        check("rst_clr_flush", 32'(rf_we), 32'd1);

        // Randomized stream
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] op;
            if ($urandom_range(0, 7) == 0) op = 5'($urandom);
            else                           op = valid_ops[$urandom_range(0, 8)];
            step(op, 3'($urandom), ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom),
                 1'($urandom), ($urandom_range(0, 31) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
